// File: rtl/dmem_arbiter_if.sv
// Master-side bus of the data-RAM arbiter: two request/ack ports sharing
// one response path (rdata/err).
interface dmem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata;
    logic        err;

    // Seen from the requesting masters (CPU memory stage and debug/loader).
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, err
    );

    // Seen from the arbiter.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data RAM.
// Every access walks IDLE -> ISSUE -> RESP; accesses to I/O space, misaligned
// or beyond the RAM depth are acknowledged with err and never reach the RAM.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    dmem_arbiter_if.slave     bus,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;   // port of the transaction in flight
    logic                last_q, last_d;     // port granted most recently
    logic                we_q, we_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;

    logic                grant;
    logic [31:0]         sel_addr;

    // Next-state logic: arbitration and latching in IDLE, bookkeeping in RESP.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        valid_d  = valid_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        grant    = 1'b0;
        sel_addr = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // A tie goes to the port that did not own the previous access.
                    grant    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    sel_addr = grant ? bus.addr1 : bus.addr0;
                    owner_d  = grant;
                    we_d     = grant ? bus.we1 : bus.we0;
                    wdata_d  = grant ? bus.wdata1 : bus.wdata0;
                    waddr_d  = sel_addr[ADDR_W+1:2];
                    // Bit 31 selects I/O space; bits above the RAM depth must be clear.
                    valid_d  = (sel_addr[31:ADDR_W+2] == '0) && (sel_addr[1:0] == 2'b00);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                last_d = owner_q;
                if (!owner_q && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
                if ( owner_q && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched-request registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!resetn) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    // RAM strobes come from state only; resetn gating kills a write caught mid-ISSUE.
    always_comb begin
        ram_en    = resetn && (state_q == S_ISSUE) && valid_q;
        ram_we    = ram_en && we_q;
        ram_addr  = waddr_q;
        ram_wdata = wdata_q;
        busy      = (state_q != S_IDLE);
        cnt0      = cnt0_q;
        cnt1      = cnt1_q;
    end

    // Response decode: ack/err/rdata depend only on state and latched fields.
    always_comb begin
        bus.ack0  = 1'b0;
        bus.ack1  = 1'b0;
        bus.err   = 1'b0;
        bus.rdata = '0;
        if (state_q == S_RESP) begin
            bus.ack0 = !owner_q;
            bus.ack1 = owner_q;
            bus.err  = !valid_q;
            if (valid_q && !we_q) bus.rdata = ram_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table of single transactions,
// then hand-written sequences for round-robin, reset mid-ISSUE and counter
// saturation (second instance with CNT_W=2).
module tb_dmem_arbiter;
    localparam int ADDR_W = 5;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    dmem_arbiter_if bus ();
    dmem_arbiter_if bus_s ();

    logic              busy, ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'h0;
    logic [15:0]       cnt0, cnt1;

    logic              s_busy, s_en, s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata;
    logic [1:0]        s_cnt0, s_cnt1;

    dmem_arbiter #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus),
        .busy      (busy),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    dmem_arbiter #(.ADDR_W(ADDR_W), .CNT_W(2)) u_sat (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus_s),
        .busy      (s_busy),
        .ram_en    (s_en),
        .ram_we    (s_we),
        .ram_addr  (s_addr),
        .ram_wdata (s_wdata),
        .ram_rdata (32'h0),
        .cnt0      (s_cnt0),
        .cnt1      (s_cnt1)
    );

    // Synchronous single-port RAM model, one-cycle read latency.
    logic [31:0] mem [32] = '{default: 32'h0};
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
        bit          exp_en;
        logic [4:0]  exp_ra;
    } vec_t;

    vec_t vecs [10];
    int   m0, m1;

    // One transaction on the main instance; returns what was seen in ISSUE and RESP.
    task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat,
                           output bit iss_en, output bit iss_we, output logic [4:0] iss_ra,
                           output bit ack_own, output bit ack_other,
                           output bit got_err, output logic [31:0] got_rdata);
        if (!port) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
        lat = 99; iss_en = 1'b0; iss_we = 1'b0; iss_ra = '0;
        ack_own = 1'b0; ack_other = 1'b0; got_err = 1'b0; got_rdata = '0;
        @(posedge clock);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) begin
                iss_en = ram_en; iss_we = ram_we; iss_ra = ram_addr;
            end
            if (bus.ack0 || bus.ack1) begin
                lat       = k;
                ack_own   = port ? bus.ack1 : bus.ack0;
                ack_other = port ? bus.ack0 : bus.ack1;
                got_err   = bus.err;
                got_rdata = bus.rdata;
                break;
            end
        end
        @(posedge clock);
        #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          iss_en, iss_we, ack_own, ack_other, got_err, acked;
        logic [4:0]  iss_ra;
        logic [31:0] got_rdata;
        int          order [8];
        int          n;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 5'd4};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 5'd4};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_007C, 32'h1234_5678, 1'b0, 32'h0,         1'b1, 5'd31};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_007C, 32'h0,         1'b0, 32'h1234_5678, 1'b1, 5'd31};
        vecs[4] = '{1'b0, 1'b0, 32'h8000_000C, 32'h0,         1'b1, 32'h0,         1'b0, 5'd0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0002, 32'h5555_AAAA, 1'b1, 32'h0,         1'b0, 5'd0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         1'b1, 32'h0,         1'b0, 5'd0};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 1'b0, 32'h0,         1'b1, 5'd4};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hA5A5_0F0F, 1'b1, 5'd4};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_007C, 32'h0,         1'b0, 32'h1234_5678, 1'b1, 5'd31};

        {bus.req0, bus.req1, bus.we0, bus.we1} = '0;
        {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} = '0;
        {bus_s.req0, bus_s.req1, bus_s.we0, bus_s.we1} = '0;
        {bus_s.addr0, bus_s.addr1, bus_s.wdata0, bus_s.wdata1} = '0;

        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check("rst_busy",  busy,      0);
        check("rst_ack",   {bus.ack1, bus.ack0}, 0);
        check("rst_err",   bus.err,   0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_ram",   {ram_en, ram_we, ram_addr}, 0);
        check("rst_cnt",   {cnt1, cnt0}, 0);
        @(posedge clock);
        #1;

        // Table of single transactions.
        m0 = 0; m1 = 0;
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat,
                    iss_en, iss_we, iss_ra, ack_own, ack_other, got_err, got_rdata);
            check($sformatf("v%0d_latency", i),   lat,       2);
            check($sformatf("v%0d_ack_own", i),   ack_own,   1);
            check($sformatf("v%0d_ack_other", i), ack_other, 0);
            check($sformatf("v%0d_err", i),       got_err,   vecs[i].exp_err);
            check($sformatf("v%0d_rdata", i),     got_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_ram_en", i),    iss_en,    vecs[i].exp_en);
            check($sformatf("v%0d_ram_we", i),    iss_we,    vecs[i].exp_en && vecs[i].we);
            if (vecs[i].exp_en) check($sformatf("v%0d_ram_addr", i), iss_ra, vecs[i].exp_ra);
            if (vecs[i].port) m1++; else m0++;
            check($sformatf("v%0d_cnt0", i), cnt0, m0);
            check($sformatf("v%0d_cnt1", i), cnt1, m1);
        end

        // Round-robin: both ports request continuously, each drops for one cycle after ack.
        bus.we0 = 1'b0; bus.addr0 = 32'h10;
        bus.we1 = 1'b0; bus.addr1 = 32'h10;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            bit a0, a1;
            @(negedge clock);
            a0 = bus.ack0;
            a1 = bus.ack1;
            if (a0 && n < 8) begin order[n] = 0; n++; end
            if (a1 && n < 8) begin order[n] = 1; n++; end
            @(posedge clock);
            #1;
            bus.req0 = !a0;
            bus.req1 = !a1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("rr_count", n, 8);
        for (int i = 0; i < 8; i++) begin
            if (i < n) check($sformatf("rr_grant%0d", i), order[i], i % 2);
        end
        m0 += 4; m1 += 4;
        check("rr_cnt0", cnt0, m0);
        check("rr_cnt1", cnt1, m1);

        // Reset asserted during ISSUE of a port-0 write.
        bus.we0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 32'hCAFE_F00D;
        bus.req0 = 1'b1;
        @(posedge clock);
        #1;
        resetn   = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clock);
        check("rstiss_ram_en", ram_en, 0);
        check("rstiss_ram_we", ram_we, 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        acked = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (bus.ack0 || bus.ack1) acked = 1'b1;
        end
        check("rstiss_no_ack", acked,   0);
        check("rstiss_mem",    mem[8],  0);
        check("rstiss_cnt0",   cnt0,    0);
        check("rstiss_busy",   busy,    0);

        // Saturating 2-bit counter on the second instance.
        @(posedge clock);
        #1;
        bus_s.we0 = 1'b1;
        bus_s.addr0 = 32'h0;
        for (int i = 0; i < 5; i++) begin
            bit got;
            got = 1'b0;
            bus_s.req0 = 1'b1;
            @(posedge clock);
            for (int k = 0; k < 8; k++) begin
                @(negedge clock);
                if (bus_s.ack0) begin got = 1'b1; break; end
            end
            @(posedge clock);
            #1 bus_s.req0 = 1'b0;
            check($sformatf("sat_ack%0d", i),  got,    1);
            check($sformatf("sat_cnt0_%0d", i), s_cnt0, (i < 2) ? i + 1 : 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port data RAM between the CPU memory stage (port 0) and a debug/loader master (port 1). It sequences each access through a fixed three-state handshake and applies round-robin priority when both masters request together. It rejects I/O-space, misaligned or out-of-range addresses without touching the RAM. It sits between the masters and the RAM instance, in place of a direct CPU-to-RAM connection.

## Interface
- ADDR_W, 5, RAM word-address width; RAM depth is 2^ADDR_W words
- CNT_W, 16, width of per-port completed-transaction counters
- clock  in  1  single system clock, all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- req0 / req1  in  1  access request from port 0 / port 1; held high until ack
- we0 / we1  in  1  write enable of the request; held stable while req is high
- addr0 / addr1  in  32  byte address; held stable while req is high
- wdata0 / wdata1  in  32  write data; held stable while req is high
- ack0 / ack1  out  1  one-cycle completion pulse to the owning port
- rdata  out  32  read data, valid only while ack0 or ack1 is high
- err  out  1  high with ack when the access was rejected
- busy  out  1  high in ISSUE and RESP
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM word index (byte address bits [ADDR_W+1:2])
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, synchronous, valid one cycle after ram_en
- cnt0 / cnt1  out  CNT_W  completed transactions per port, saturating

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if neither req is high, stay. Otherwise pick the owner and latch its we, addr and wdata into internal registers. Latch valid = (addr[31]==0) && (addr[1:0]==0) && (addr[30:ADDR_W+2]==0). Go to ISSUE.
- Arbitration: only one req high → that port wins. Both high → the port not granted last wins. The last-owner register resets to 1, so port 0 wins the first tie.
- ISSUE: if valid, ram_en=1, ram_we=latched we, ram_addr=latched addr[ADDR_W+1:2], ram_wdata=latched wdata. If not valid, ram_en=ram_we=0. Always go to RESP.
- RESP:
  - ack of the owner = 1; err = !valid.
  - rdata = ram_rdata for a valid read. rdata = 0 for writes and rejected accesses.
  - Update last-owner to the current owner.
  - Increment the owner's counter unless it is already all-ones (saturates, no wrap).
  - Go to IDLE.
- Outside RESP: ack0=ack1=err=0 and rdata=0. Outside ISSUE: ram_en=ram_we=0. ram_addr and ram_wdata show the latched values and are don't-care when ram_en=0.
- Requests are not pre-empted. A req raised while busy is sampled at the next IDLE.
- A master that drops req before ack is a protocol violation. The transaction already latched still completes and acks.
- Reset: state=IDLE, last-owner=1, latched fields=0, cnt0=cnt1=0, all outputs 0.
- ram_en and ram_we are gated combinationally with resetn. A reset asserted during ISSUE suppresses the write, no ack is produced, and the counters do not change.

## Timing
- Latency: req sampled high at edge N (end of IDLE). ISSUE occupies cycle N+1, RESP occupies cycle N+2, and ack is high during N+2.
- The master samples ack at the end of N+2 and must drop req in N+3. The arbiter is in IDLE in N+3 and samples req at the end of that cycle.
- Maximum throughput: one transaction per 3 cycles.
- A write commits at the edge ending ISSUE. A read returns ram_rdata in RESP, matching the RAM's one-cycle read latency.
- cnt updates at the edge ending RESP.
- ack, err and rdata are decoded from state and latched fields with no combinational path from any req.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to 0x0000_0010 → ram_en=ram_we=1 and ram_addr=4 in cycle 2; ack0 in cycle 3 with err=0; cnt0=1.
- Port 1 reads 0x0000_0010 after that write → ack1 in cycle 3 with rdata=0xDEADBEEF and err=0; ack0 stays 0.
- req0 and req1 held continuously, each dropped for one cycle after its ack → grants alternate 0,1,0,1. Both cnt0 and cnt1 reach 4 after 8 transactions.
- Port 0 accesses 0x8000_000C, then 0x0000_0002, then 0x0000_0080 (ADDR_W=5) → ram_en stays 0 for all three; each ack0 comes with err=1 and rdata=0.
- Port 0 write with resetn driven low during ISSUE → ram_we low in that cycle; no ack; RAM contents unchanged; cnt0=0 and state IDLE after reset.
- CNT_W=2, 5 port-0 transactions → cnt0 sequence 1,2,3,3,3.
